// File: rtl/video_frame_writer_pkg.sv
// Shared definitions for the video frame writer: buffer geometry defaults and
// the write-side state type.
package video_pkg;

    localparam int unsigned VIDEO_WORD_W         = 16;
    localparam int unsigned VIDEO_MEM_CELL_COUNT = 1200;
    localparam int unsigned VIDEO_ADDR_W         = 11;

    typedef enum logic [1:0] {
        REQ,
        FILL,
        FULL
    } vfw_state_t;

endpackage

// File: rtl/video_frame_writer_bit_packer.sv
// Serial-to-word packer: shifts payload bits in MSB first and flags the sample
// that completes a word; clear_i discards any partial word.
module bit_packer
    import video_pkg::*;
#(
    parameter int unsigned WORD_W = VIDEO_WORD_W
) (
    input  logic              CLK_40,
    input  logic              rst,
    input  logic              sample_i,
    input  logic              bit_i,
    input  logic              clear_i,
    output logic              word_done_o,
    output logic              bits_pending_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int unsigned       CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    assign bits_pending_o = (bit_cnt_q != '0);

    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        word_o      = {shreg_q[WORD_W-2:0], bit_i};
        word_done_o = sample_i && (bit_cnt_q == LAST_BIT) && !clear_i;
        if (clear_i) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (sample_i) begin
            shreg_d   = word_o;
            bit_cnt_d = word_done_o ? '0 : bit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK_40 or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/video_frame_writer.sv
// Video frame writer: packs the SPI video bit stream into words, fills the back
// bank of a ping-pong frame buffer and swaps banks on the display's frame-done.
module video_frame_writer
    import video_pkg::*;
#(
    parameter int unsigned WORD_W     = VIDEO_WORD_W,
    parameter int unsigned CELL_COUNT = VIDEO_MEM_CELL_COUNT,
    parameter int unsigned ADDR_W     = VIDEO_ADDR_W
) (
    input  logic              CLK_40,
    input  logic              rst,
    input  logic              data_clk_rising_edge,
    input  logic              video_data_ready,
    input  logic              received_bit,
    input  logic              chip_select,
    input  logic              disp_frame_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_bank,
    output logic              disp_bank,
    output logic              frame_ready,
    output logic              frame_req,
    output logic              overflow_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_COUNT - 1);

    vfw_state_t        state_q, state_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_bank_q, wr_bank_d;
    logic              disp_bank_q, disp_bank_d;
    logic              frame_ready_q, frame_ready_d;
    logic              frame_req_q, frame_req_d;
    logic              overflow_q, overflow_d;
    logic              cs_q;

    logic              sample, fill_sample, cs_rise, abort;
    logic              word_done, bits_pending;
    logic [WORD_W-1:0] packed_word;

    assign sample      = data_clk_rising_edge & video_data_ready;
    assign fill_sample = sample & (state_q == FILL);
    assign cs_rise     = chip_select & ~cs_q;
    // A deselect only aborts once something of the frame has been received.
    assign abort       = (state_q == FILL) & cs_rise & (bits_pending | (word_cnt_q != '0));

    bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .CLK_40         (CLK_40),
        .rst            (rst),
        .sample_i       (fill_sample),
        .bit_i          (received_bit),
        .clear_i        (abort),
        .word_done_o    (word_done),
        .bits_pending_o (bits_pending),
        .word_o         (packed_word)
    );

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_bank_d     = wr_bank_q;
        disp_bank_d   = disp_bank_q;
        frame_ready_d = frame_ready_q;
        frame_req_d   = 1'b0;
        overflow_d    = overflow_q;
        case (state_q)
            REQ: begin
                frame_req_d = 1'b1;
                state_d     = FILL;
            end
            FILL: begin
                if (abort) begin
                    word_cnt_d = '0;
                    state_d    = REQ;
                end else if (word_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = word_cnt_q;
                    wr_data_d = packed_word;
                    if (word_cnt_q == LAST_ADDR) begin
                        word_cnt_d    = '0;
                        frame_ready_d = 1'b1;
                        state_d       = FULL;
                    end else begin
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                    end
                end
            end
            FULL: begin
                if (sample) begin
                    overflow_d = 1'b1;
                end
                if (disp_frame_done) begin
                    disp_bank_d   = wr_bank_q;
                    wr_bank_d     = ~wr_bank_q;
                    frame_ready_d = 1'b0;
                    state_d       = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge CLK_40 or posedge rst) begin
        if (rst) begin
            state_q       <= REQ;
            word_cnt_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_bank_q     <= 1'b1;
            disp_bank_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_req_q   <= 1'b0;
            overflow_q    <= 1'b0;
            cs_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_bank_q     <= wr_bank_d;
            disp_bank_q   <= disp_bank_d;
            frame_ready_q <= frame_ready_d;
            frame_req_q   <= frame_req_d;
            overflow_q    <= overflow_d;
            cs_q          <= chip_select;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_bank      = wr_bank_q;
    assign disp_bank    = disp_bank_q;
    assign frame_ready  = frame_ready_q;
    assign frame_req    = frame_req_q;
    assign overflow_err = overflow_q;

endmodule

// File: doc/video_frame_writer.md
Name: video_frame_writer

Overview:
- Downstream consumer of the SPI data-receive FSM's video stream.
- Deserialises the received bit stream (received_bit, qualified by video_data_ready on data-clock rising edges) into WORD_W-bit words and writes them sequentially into the back bank of a ping-pong video frame buffer.
- Swaps banks with the display side on a frame-done handshake, and pulses frame_req to start the next SPI transfer.

Parameters:
- WORD_W, 16: bits per memory cell; MSB received first.
- CELL_COUNT, 1200: words per frame; equals VIDEO_MEM_CELL_COUNT from params.
- ADDR_W, 11: width of wr_addr; must satisfy 2^ADDR_W >= CELL_COUNT.

Ports:
- CLK_40  in  1  system clock, 40 MHz.
- rst  in  1  asynchronous, active-high reset.
- data_clk_rising_edge  in  1  one-CLK_40-cycle strobe, data clock rising edge.
- video_data_ready  in  1  received_bit is valid video payload.
- received_bit  in  1  serial video bit from the receive FSM.
- chip_select  in  1  SPI SS, active low; a 0->1 transition ends a transfer.
- disp_frame_done  in  1  one-cycle pulse from the display at end of frame (vsync).
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  word address within the bank.
- wr_data  out  WORD_W  packed word.
- wr_bank  out  1  bank currently being written.
- disp_bank  out  1  bank the display reads.
- frame_ready  out  1  back bank holds a complete frame.
- frame_req  out  1  one-cycle pulse requesting the next SPI transfer (drives start_req).
- overflow_err  out  1  sticky: payload bit arrived while not accepting.

Behaviour:
- Reset (async, rst=1) values:
  - state=REQ
  - wr_en=0, wr_addr=0, wr_data=0
  - wr_bank=1, disp_bank=0
  - frame_ready=0, frame_req=0, overflow_err=0
  - shift register=0, bit_cnt=0, word_cnt=0
- Sample event: CLK_40 edge with data_clk_rising_edge=1 and video_data_ready=1.
- States:
  - REQ: frame_req=1 for exactly one cycle, then -> FILL.
  - FILL: accept samples.
    - Shift: shreg <= {shreg[WORD_W-2:0], received_bit}; bit_cnt++.
    - When a sample completes a word (bit_cnt==WORD_W-1 before the sample):
      - Next cycle: wr_en=1, wr_data=completed word, wr_addr=word_cnt; bit_cnt -> 0.
      - word_cnt++ together with the write.
    - Write latency: 1 CLK_40 cycle from the completing sample.
    - Completing word CELL_COUNT-1: word_cnt -> 0, state -> FULL, frame_ready=1, asserted in the same cycle as the final wr_en.
  - FULL: no writes.
    - Each sample event sets overflow_err=1. It is sticky until rst.
    - disp_frame_done=1: disp_bank<=wr_bank, wr_bank<=~wr_bank, frame_ready<=0, state -> REQ.
- Abort: chip_select 0->1 in FILL with (bit_cnt!=0 or word_cnt!=0).
  - Discard the partial frame: bit_cnt=0, word_cnt=0.
  - State -> REQ, so the transfer is re-requested.
  - wr_bank unchanged; disp_bank unchanged.
- chip_select 0->1 in FULL or REQ: no effect.
- disp_frame_done in REQ or FILL: ignored; the display repeats the current frame and the bank does not change.
- Simultaneous sample event and disp_frame_done in FULL: swap occurs; the sample counts as overflow.
- Same-cycle chip_select deassert and word completion in FILL: abort wins; the pending write is suppressed.
- video_data_ready=0 during FILL: hold all counters; no timeout.
- rst mid-frame: everything returns to reset values immediately; the partially written bank contents are undefined, and display_bank=0 is shown.
- Widths: bit_cnt is $clog2(WORD_W) bits; word_cnt is ADDR_W bits and wraps only via the CELL_COUNT-1 compare, never naturally.

Decomposition:
- Shared package video_pkg:
  - typedef enum logic [1:0] {REQ, FILL, FULL} vfw_state_t
  - WORD_W and CELL_COUNT defaults tied to the params.sv defines
- Sub-module bit_packer (shift register, bit_cnt, word-complete strobe, abort clear). The FSM and bank control stay in the top module.

Test Plan:
- Reset release -> frame_req pulses 1 cycle, on the 1st cycle after reset; wr_bank=1, disp_bank=0, frame_ready=0.
- Feed 16 samples of 0xA5C3, MSB first -> wr_en=1 exactly one cycle after the 16th sample, wr_addr=0, wr_data=0xA5C3.
- Feed CELL_COUNT*WORD_W bits (word i = i) -> CELL_COUNT writes, addresses 0..1199 in order; frame_ready=1 on the final write; state FULL.
- In FULL: 3 extra samples -> overflow_err=1 and stays 1. Then pulse disp_frame_done -> disp_bank=1, wr_bank=0, frame_ready=0, frame_req pulse next cycle.
- Mid-word abort: 7 bits, then raise chip_select -> no wr_en, state REQ, frame_req pulse. Next full word is written at wr_addr=0.
- disp_frame_done pulsed during FILL at word 500 -> banks unchanged; filling continues at wr_addr=500.
